wb_trace_checker: RTL and testbench

//   Consumes the CPU debug write-back port inside soc_top and checks every

---
 rtl/wb_trace_checker.sv | 178 +++++++++++++++++
 tb/tb_wb_trace_checker.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Write-back trace checker: buffers CPU register-file writes in a FIFO
// and compares each one against a golden trace stream.
module wb_trace_checker #(
    parameter int unsigned DEPTH  = 8,
    parameter logic [31:0] END_PC = 32'hbfc00100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_wen,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        ref_valid,
    output logic        ref_ready,
    input  logic [31:0] ref_pc,
    input  logic [4:0]  ref_wnum,
    input  logic [31:0] ref_wdata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc,
    output logic [31:0] err_got,
    output logic [31:0] err_exp,
    output logic [31:0] checked_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } wb_ent_t;

    typedef enum logic [1:0] {
        S_RUN,
        S_FAIL,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    wb_ent_t     mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic        end_seen_q, end_seen_d;
    logic [31:0] checked_q, checked_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] err_pc_q, err_pc_d;
    logic [31:0] err_got_q, err_got_d;
    logic [31:0] err_exp_q, err_exp_d;

    logic        run;
    logic        empty;
    logic        full;
    logic        xfer;
    logic        want_push;
    logic        push;
    logic        ovf;
    logic        ok;
    logic        mismatch;
    logic        is_end;
    wb_ent_t     head;
    logic [31:0] mask;

    assign run       = (state_q == S_RUN);
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == FULL_CNT);
    // Gate with rst so an in-flight golden entry is never consumed in reset
    assign ref_ready = run & ~empty & ~rst;
    assign xfer      = ref_valid & ref_ready;
    assign head      = mem_q[rd_ptr_q];
    assign mask      = {{8{head.wen[3]}}, {8{head.wen[2]}},
                        {8{head.wen[1]}}, {8{head.wen[0]}}};
    assign ok        = (head.pc == ref_pc) && (head.wnum == ref_wnum) &&
                       ((head.wdata & mask) == (ref_wdata & mask));
    assign mismatch  = xfer & ~ok;
    assign want_push = run && (debug_wb_rf_wen != 4'd0) &&
                       (debug_wb_rf_wnum != 5'd0);
    assign ovf       = want_push & full & ~xfer;
    assign push      = want_push & ~ovf;
    assign is_end    = (debug_wb_rf_wen != 4'd0) && (debug_wb_pc == END_PC);

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        end_seen_d = end_seen_q | is_end;
        checked_d  = checked_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        err_got_d  = err_got_q;
        err_exp_d  = err_exp_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (xfer) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !xfer) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!push && xfer) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
        if (xfer && ok) begin
            checked_d = checked_q + 32'd1;
        end

        unique case (state_q)
            S_RUN: begin
                if (ovf) begin
                    state_d    = S_FAIL;
                    err_code_d = 2'b10;
                    err_pc_d   = debug_wb_pc;
                end else if (mismatch) begin
                    state_d    = S_FAIL;
                    err_code_d = 2'b01;
                    err_pc_d   = head.pc;
                    err_got_d  = head.wdata & mask;
                    err_exp_d  = ref_wdata & mask;
                end else if (end_seen_q && empty && !xfer) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{pc:    debug_wb_pc,
                                 wnum:  debug_wb_rf_wnum,
                                 wen:   debug_wb_rf_wen,
                                 wdata: debug_wb_rf_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            end_seen_q <= 1'b0;
            checked_q  <= '0;
            err_code_q <= '0;
            err_pc_q   <= '0;
            err_got_q  <= '0;
            err_exp_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            end_seen_q <= end_seen_d;
            checked_q  <= checked_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            err_got_q  <= err_got_d;
            err_exp_q  <= err_exp_d;
        end
    end

    assign done        = (state_q == S_DONE);
    assign pass        = done;
    assign fail        = (state_q == S_FAIL);
    assign err_code    = err_code_q;
    assign err_pc      = err_pc_q;
    assign err_got     = err_got_q;
    assign err_exp     = err_exp_q;
    assign checked_cnt = checked_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed scenarios plus a randomized run
// against a queue-based reference model of the checking rules.
module tb_wb_trace_checker;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] END_PC = 32'hbfc00100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] debug_wb_pc = '0;
    logic [3:0]  debug_wb_rf_wen = '0;
    logic [4:0]  debug_wb_rf_wnum = '0;
    logic [31:0] debug_wb_rf_wdata = '0;
    logic        ref_valid = 1'b0;
    logic        ref_ready;
    logic [31:0] ref_pc = '0;
    logic [4:0]  ref_wnum = '0;
    logic [31:0] ref_wdata = '0;
    logic        done, pass, fail;
    logic [1:0]  err_code;
    logic [31:0] err_pc, err_got, err_exp, checked_cnt;

    wb_trace_checker #(.DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk(clk), .rst(rst),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
        .ref_wnum(ref_wnum), .ref_wdata(ref_wdata),
        .done(done), .pass(pass), .fail(fail), .err_code(err_code),
        .err_pc(err_pc), .err_got(err_got), .err_exp(err_exp),
        .checked_cnt(checked_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } gold_t;

    // Reference model: pending write-backs, verdict state, error record
    ent_t        mq[$];
    gold_t       gq[$];
    int          m_st;
    bit          m_end;
    logic [31:0] m_cnt;
    logic [1:0]  m_code;
    logic [31:0] m_epc, m_got, m_exp;

    int errs = 0;
    int checks = 0;
    bit rv_en;
    bit obs_rdy, exp_rdy;
    int rdy_pulses;

    function automatic logic [31:0] bmask(input logic [3:0] w);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{w[i]}};
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_st = 0; m_end = 0; m_cnt = 0;
        m_code = 0; m_epc = 0; m_got = 0; m_exp = 0;
    endtask

    task automatic model_step(input logic [31:0] pc, input logic [3:0] wen,
                              input logic [4:0] wnum, input logic [31:0] wd);
        int sz;
        bit xf, mis, ovf;
        ent_t h;
        logic [31:0] m;
        sz = mq.size();
        xf = ref_valid && exp_rdy;
        mis = 0; ovf = 0; m = 0;
        if (xf) begin
            h = mq.pop_front();
            m = bmask(h.wen);
            if (h.pc == ref_pc && h.wnum == ref_wnum &&
                (h.wdata & m) == (ref_wdata & m)) m_cnt = m_cnt + 1;
            else mis = 1;
        end
        if (m_st == 0 && wen != 0 && wnum != 0) begin
            if (sz == DEPTH && !xf) ovf = 1;
            else mq.push_back('{pc, wnum, wen, wd});
        end
        if (m_st == 0) begin
            if (ovf) begin
                m_st = 1; m_code = 2; m_epc = pc;
            end else if (mis) begin
                m_st = 1; m_code = 1; m_epc = h.pc;
                m_got = h.wdata & m; m_exp = ref_wdata & m;
            end else if (m_end && sz == 0) begin
                m_st = 2;
            end
        end
        if (wen != 0 && pc == END_PC) m_end = 1;
    endtask

    // One clock cycle: drive, sample handshake mid-cycle, advance model
    task automatic cycle(input logic [31:0] pc, input logic [3:0] wen,
                         input logic [4:0] wnum, input logic [31:0] wd,
                         input bit r);
        rst = r;
        debug_wb_pc = pc; debug_wb_rf_wen = wen;
        debug_wb_rf_wnum = wnum; debug_wb_rf_wdata = wd;
        ref_valid = rv_en && gq.size() > 0;
        if (gq.size() > 0) begin
            ref_pc = gq[0].pc; ref_wnum = gq[0].wnum; ref_wdata = gq[0].wdata;
        end else begin
            ref_pc = 0; ref_wnum = 0; ref_wdata = 0;
        end
        @(negedge clk);
        obs_rdy = ref_ready;
        exp_rdy = !r && m_st == 0 && mq.size() > 0;
        if (r) model_reset();
        else model_step(pc, wen, wnum, wd);
        if (ref_valid && ref_ready) begin
            void'(gq.pop_front());
            rdy_pulses++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] pc, input logic [4:0] wnum,
                      input logic [31:0] wd, input logic [3:0] wen,
                      input logic [31:0] gwd);
        gq.push_back('{pc, wnum, gwd});
        cycle(pc, wen, wnum, wd, 0);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        gq.delete();
        cycle(0, 0, 0, 0, 1);
        rdy_pulses = 0;
    endtask

    task automatic test_reset();
        rv_en = 1;
        do_reset();
        checks++; if (obs_rdy !== 1'b0) begin errs++; $display("FAIL reset_rdy got %b exp 0", obs_rdy); end
        checks++; if ({done, pass, fail} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b exp 000", {done, pass, fail}); end
        checks++; if (err_code !== 2'b00) begin errs++; $display("FAIL reset_code got %b exp 00", err_code); end
        checks++; if ({err_pc, err_got, err_exp} !== 96'd0) begin errs++; $display("FAIL reset_err got %h exp 0", {err_pc, err_got, err_exp}); end
        checks++; if (checked_cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", checked_cnt); end
    endtask

    task automatic test_basic();
        rv_en = 1;
        do_reset();
        wr(32'h1000, 5'd1, 32'h11, 4'hf, 32'h11);
        checks++; if (checked_cnt !== 32'd0) begin errs++; $display("FAIL basic_lat0 got %0d exp 0", checked_cnt); end
        wr(32'h1004, 5'd2, 32'h22, 4'hf, 32'h22);
        checks++; if (checked_cnt !== 32'd1) begin errs++; $display("FAIL basic_lat1 got %0d exp 1", checked_cnt); end
        wr(32'h1008, 5'd3, 32'h33, 4'hf, 32'h33);
        repeat (4) idle();
        checks++; if (checked_cnt !== 32'd3) begin errs++; $display("FAIL basic_cnt got %0d exp 3", checked_cnt); end
        checks++; if (fail !== 1'b0) begin errs++; $display("FAIL basic_fail got %b exp 0", fail); end
        checks++; if (rdy_pulses !== 3) begin errs++; $display("FAIL basic_pulses got %0d exp 3", rdy_pulses); end
    endtask

    task automatic test_mismatch();
        rv_en = 1;
        do_reset();
        wr(32'h2000, 5'd5, 32'h12345678, 4'hf, 32'h12345679);
        checks++; if (fail !== 1'b0) begin errs++; $display("FAIL mis_early got %b exp 0", fail); end
        idle();
        checks++; if (fail !== 1'b1) begin errs++; $display("FAIL mis_fail got %b exp 1", fail); end
        checks++; if (err_code !== 2'b01) begin errs++; $display("FAIL mis_code got %b exp 01", err_code); end
        checks++; if (err_pc !== 32'h2000) begin errs++; $display("FAIL mis_pc got %h exp 00002000", err_pc); end
        checks++; if (err_got !== 32'h12345678) begin errs++; $display("FAIL mis_got got %h exp 12345678", err_got); end
        checks++; if (err_exp !== 32'h12345679) begin errs++; $display("FAIL mis_exp got %h exp 12345679", err_exp); end
        wr(32'h2004, 5'd6, 32'h1, 4'hf, 32'h1);
        checks++; if (obs_rdy !== 1'b0) begin errs++; $display("FAIL mis_rdy got %b exp 0", obs_rdy); end
        checks++; if (pass !== 1'b0) begin errs++; $display("FAIL mis_pass got %b exp 0", pass); end
    endtask

    task automatic test_mask();
        rv_en = 1;
        do_reset();
        wr(32'h3000, 5'd7, 32'hAAAA1234, 4'b0011, 32'h55551234);
        idle();
        checks++; if (fail !== 1'b0) begin errs++; $display("FAIL mask_fail got %b exp 0", fail); end
        checks++; if (checked_cnt !== 32'd1) begin errs++; $display("FAIL mask_cnt got %0d exp 1", checked_cnt); end
    endtask

    task automatic test_overflow();
        rv_en = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr(32'h4000 + 32'(4 * i), 5'(i + 1), 32'(i), 4'hf, 32'(i));
            if (i == 3) begin
                checks++; if (fail !== 1'b0) begin errs++; $display("FAIL ovf_early got %b exp 0", fail); end
            end
        end
        checks++; if (fail !== 1'b1) begin errs++; $display("FAIL ovf_fail got %b exp 1", fail); end
        checks++; if (err_code !== 2'b10) begin errs++; $display("FAIL ovf_code got %b exp 10", err_code); end
        checks++; if (err_pc !== 32'h4010) begin errs++; $display("FAIL ovf_pc got %h exp 00004010", err_pc); end
        rv_en = 1;
        idle();
        checks++; if (obs_rdy !== 1'b0) begin errs++; $display("FAIL ovf_rdy got %b exp 0", obs_rdy); end
        checks++; if (checked_cnt !== 32'd0) begin errs++; $display("FAIL ovf_cnt got %0d exp 0", checked_cnt); end
    endtask

    task automatic test_end();
        rv_en = 1;
        do_reset();
        cycle(32'h5000, 4'hf, 5'd0, 32'h55, 0);
        wr(32'h5004, 5'd4, 32'h77, 4'hf, 32'h77);
        repeat (2) idle();
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL end_early got %b exp 0", done); end
        cycle(END_PC, 4'hf, 5'd0, 32'h0, 0);
        repeat (2) idle();
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL end_done got %b exp 1", done); end
        checks++; if (pass !== 1'b1) begin errs++; $display("FAIL end_pass got %b exp 1", pass); end
        checks++; if (fail !== 1'b0) begin errs++; $display("FAIL end_fail got %b exp 0", fail); end
        checks++; if (checked_cnt !== 32'd1) begin errs++; $display("FAIL end_cnt got %0d exp 1", checked_cnt); end
    endtask

    task automatic test_rst_mid();
        rv_en = 0;
        do_reset();
        wr(32'h6000, 5'd8, 32'h8, 4'hf, 32'h8);
        wr(32'h6004, 5'd9, 32'h9, 4'hf, 32'h9);
        rv_en = 1;
        cycle(0, 0, 0, 0, 1);
        checks++; if (obs_rdy !== 1'b0) begin errs++; $display("FAIL rstm_rdy got %b exp 0", obs_rdy); end
        checks++; if ({done, pass, fail, err_code} !== 5'd0) begin errs++; $display("FAIL rstm_flags got %b exp 0", {done, pass, fail, err_code}); end
        checks++; if (checked_cnt !== 32'd0) begin errs++; $display("FAIL rstm_cnt got %0d exp 0", checked_cnt); end
        gq.delete();
        idle();
        checks++; if (obs_rdy !== 1'b0) begin errs++; $display("FAIL rstm_empty got %b exp 0", obs_rdy); end
        wr(32'h6100, 5'd10, 32'hA, 4'hf, 32'hA);
        wr(32'h6104, 5'd11, 32'hB, 4'hf, 32'hB);
        repeat (2) idle();
        checks++; if (checked_cnt !== 32'd2) begin errs++; $display("FAIL rstm_after got %0d exp 2", checked_cnt); end
        checks++; if (fail !== 1'b0) begin errs++; $display("FAIL rstm_fail got %b exp 0", fail); end
    endtask

    task automatic test_random();
        logic [31:0] pc, wd, gwd;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        for (int k = 0; k < 4; k++) begin
            rv_en = 1;
            do_reset();
            for (int n = 0; n < 100; n++) begin
                pc   = $urandom & 32'h7ffffffc;
                wd   = $urandom;
                wen  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
                wnum = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                rv_en = ($urandom_range(0, 3) != 0);
                if (wen != 0 && wnum != 0) begin
                    gwd = wd;
                    if ($urandom_range(0, 59) == 0) gwd = wd ^ (32'd1 << $urandom_range(0, 31));
                    wr(pc, wnum, wd, wen, gwd);
                end else begin
                    cycle(pc, wen, wnum, wd, 0);
                end
                checks++; if (obs_rdy !== exp_rdy) begin errs++; $display("FAIL rnd_rdy n=%0d got %b exp %b", n, obs_rdy, exp_rdy); end
                checks++; if (checked_cnt !== m_cnt) begin errs++; $display("FAIL rnd_cnt n=%0d got %0d exp %0d", n, checked_cnt, m_cnt); end
                checks++; if (fail !== (m_st == 1)) begin errs++; $display("FAIL rnd_fail n=%0d got %b exp %b", n, fail, m_st == 1); end
                checks++; if (done !== (m_st == 2)) begin errs++; $display("FAIL rnd_done n=%0d got %b exp %b", n, done, m_st == 2); end
                checks++; if (err_code !== m_code) begin errs++; $display("FAIL rnd_code n=%0d got %b exp %b", n, err_code, m_code); end
                checks++; if (err_pc !== m_epc) begin errs++; $display("FAIL rnd_epc n=%0d got %h exp %h", n, err_pc, m_epc); end
                checks++; if (err_got !== m_got) begin errs++; $display("FAIL rnd_got n=%0d got %h exp %h", n, err_got, m_got); end
                checks++; if (err_exp !== m_exp) begin errs++; $display("FAIL rnd_exp n=%0d got %h exp %h", n, err_exp, m_exp); end
            end
        end
    endtask

    initial begin
        model_reset();
        rv_en = 0;
        rdy_pulses = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_mismatch();
        test_mask();
        test_overflow();
        test_end();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
